pipeline_control: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V core. It consumes the load-use stall from the hazard detector, branch/jump redirects resolved in ID, the data-memory ready handshake and a halt request, and turns them into per-stage write enables, bubbles, flushes and valid bits. It also keeps the core's performance counters. It sits beside the pipeline registers and drives every pipeline-register enable.

---
 rtl/pipeline_control_pkg.sv | 21 ++
 rtl/pipeline_control_perf_counters.sv | 57 +++++
 rtl/pipeline_control.sv | 157 +++++++++++++++
 tb/tb_pipeline_control.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM states,
// stage indices into the valid-bit vector and the default counter width.
package pipeline_control_pkg;

    localparam int CNT_W_DEF = 32;

    localparam int STG_ID  = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;
    localparam int N_STG   = 4;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4
    } state_e;

endpackage

// File: rtl/pipeline_control_perf_counters.sv
// Core performance counters: four wrapping counters with per-counter
// increment strobes and a global freeze used once the core has halted.
module pipeline_control_perf_counters
    import pipeline_control_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze_i,
    input  logic             retire_inc_i,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        cycle_d  = cycle_q;
        retire_d = retire_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        if (!freeze_i) begin
            cycle_d = cycle_q + CNT_W'(1);
            if (retire_inc_i) retire_d = retire_q + CNT_W'(1);
            if (stall_inc_i)  stall_d  = stall_q + CNT_W'(1);
            if (flush_inc_i)  flush_d  = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign cycle_cnt_o  = cycle_q;
    assign retire_cnt_o = retire_q;
    assign stall_cnt_o  = stall_q;
    assign flush_cnt_o  = flush_q;

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage core: turns hazard, redirect, data
// memory and halt events into pipeline-register enables and stage valid bits.
//
//   state    | meaning
//   BOOT     | one cycle after reset, everything idle
//   RUN      | normal flow, stalls/redirects/halt accept evaluated
//   MEM_WAIT | data access outstanding, whole pipeline frozen
//   DRAIN    | fetch stopped, older instructions (and ECALL) retiring
//   HALTED   | drained and stopped until reset
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic             retire,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q, state_d;
    logic             from_drain_q, from_drain_d;
    logic [N_STG-1:0] v_q, v_d;
    logic             run_rules, drain_rules, mem_stall;
    logic             stall_inc, flush_inc;

    assign mem_stall = v_q[STG_MEM] & dmem_req & ~dmem_ready;

    always_comb begin
        state_d      = state_q;
        from_drain_d = from_drain_q;
        v_d          = v_q;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        run_rules    = 1'b0;
        drain_rules  = 1'b0;

        case (state_q)
            ST_BOOT:     state_d = ST_RUN;
            ST_RUN:      run_rules = 1'b1;
            ST_DRAIN:    drain_rules = 1'b1;
            ST_MEM_WAIT: begin
                if (!dmem_ready) begin
                    stall_inc = 1'b1;
                end else if (from_drain_q) begin
                    drain_rules = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_HALTED:   halted = 1'b1;
            default:     state_d = ST_BOOT;
        endcase

        // The ready cycle of MEM_WAIT completes the access, so only a fresh
        // miss seen in RUN/DRAIN enters the freeze.
        if ((state_q == ST_RUN || state_q == ST_DRAIN) && mem_stall) begin
            state_d      = ST_MEM_WAIT;
            from_drain_d = (state_q == ST_DRAIN);
            stall_inc    = 1'b1;
        end else if (run_rules || drain_rules) begin
            id_ex_we     = 1'b1;
            ex_mem_we    = 1'b1;
            mem_wb_we    = 1'b1;
            v_d[STG_ID]  = 1'b1;
            v_d[STG_EX]  = v_q[STG_ID];
            v_d[STG_MEM] = v_q[STG_EX];
            v_d[STG_WB]  = v_q[STG_MEM];
            state_d      = run_rules ? ST_RUN : ST_DRAIN;
            if (drain_rules) begin
                v_d[STG_ID] = 1'b0;
                // halted rises in the cycle the last instruction leaves WB
                if (!(v_d[STG_EX] | v_d[STG_MEM] | v_d[STG_WB])) begin
                    halted  = 1'b1;
                    state_d = ST_HALTED;
                end
            end else begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
                if (v_q[STG_ID] && hazard_stall) begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    v_d[STG_EX] = 1'b0;
                    stall_inc   = 1'b1;
                end else if (v_q[STG_ID] && redirect) begin
                    pc_sel      = 1'b1;
                    v_d[STG_ID] = 1'b0;
                    flush_inc   = 1'b1;
                end else if (v_q[STG_ID] && halt_req) begin
                    // the fetch behind ECALL must never reach EX
                    v_d[STG_ID] = 1'b0;
                    state_d     = ST_DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            from_drain_q <= 1'b0;
            v_q          <= '0;
        end else begin
            state_q      <= state_d;
            from_drain_q <= from_drain_d;
            v_q          <= v_d;
        end
    end

    assign v_id   = v_q[STG_ID];
    assign v_ex   = v_q[STG_EX];
    assign v_mem  = v_q[STG_MEM];
    assign v_wb   = v_q[STG_WB];
    assign retire = v_q[STG_WB] & mem_wb_we;

    pipeline_control_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze_i     (state_q == ST_HALTED),
        .retire_inc_i (retire),
        .stall_inc_i  (stall_inc),
        .flush_inc_i  (flush_inc),
        .cycle_cnt_o  (cycle_cnt),
        .retire_cnt_o (retire_cnt),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: a stage-occupancy reference model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_pipeline_control;

    localparam int CW  = 8;
    localparam int MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          hazard_stall = 1'b0;
    logic          redirect = 1'b0;
    logic          dmem_req = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          halt_req = 1'b0;
    logic          pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic          v_id, v_ex, v_mem, v_wb, retire, halted;
    logic [CW-1:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

    pipeline_control #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard_stall (hazard_stall),
        .redirect     (redirect),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .v_id         (v_id),
        .v_ex         (v_ex),
        .v_mem        (v_mem),
        .v_wb         (v_wb),
        .retire       (retire),
        .halted       (halted),
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   tag;
        logic [11:0]   ctl;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ret;
        logic [CW-1:0] stl;
        logic [CW-1:0] fl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_no = 0;
    event chk_ev;

    // Reference model: which stages hold an instruction, plus run/drain mode.
    localparam int M_BOOT  = 0;
    localparam int M_FLOW  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_STOP  = 3;
    int m_mode;
    bit m_wait;
    bit m_pipe [4];
    int m_cyc, m_ret, m_stall, m_flush;

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_BOOT;
        m_wait = 1'b0;
        for (int i = 0; i < 4; i++) m_pipe[i] = 1'b0;
        m_cyc = 0; m_ret = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic predict(output exp_t e);
        bit pcwe, pcsel, ifid, down, ret, hlt, busy;
        bit nxt [4];
        pcwe = 0; pcsel = 0; ifid = 0; down = 0; ret = 0; hlt = 0; busy = 0;
        e.tag = cyc_no;
        e.cyc = CW'(m_cyc);
        e.ret = CW'(m_ret);
        e.stl = CW'(m_stall);
        e.fl  = CW'(m_flush);
        nxt = m_pipe;
        if (m_mode == M_BOOT) begin
            m_mode = M_FLOW;
            m_cyc  = (m_cyc + 1) % MOD;
        end else if (m_mode == M_STOP) begin
            hlt = 1;
        end else begin
            m_cyc = (m_cyc + 1) % MOD;
            busy  = m_wait ? !dmem_ready : (m_pipe[2] && dmem_req && !dmem_ready);
            if (busy) begin
                m_wait  = 1;
                m_stall = (m_stall + 1) % MOD;
            end else begin
                m_wait = 0;
                down   = 1;
                ret    = m_pipe[3];
                nxt[3] = m_pipe[2];
                nxt[2] = m_pipe[1];
                nxt[1] = m_pipe[0];
                if (m_mode == M_DRAIN) begin
                    nxt[0] = 0;
                    if (!nxt[1] && !nxt[2] && !nxt[3]) begin
                        hlt    = 1;
                        m_mode = M_STOP;
                    end
                end else begin
                    pcwe = 1; ifid = 1; nxt[0] = 1;
                    if (m_pipe[0] && hazard_stall) begin
                        pcwe = 0; ifid = 0; nxt[1] = 0;
                        m_stall = (m_stall + 1) % MOD;
                    end else if (m_pipe[0] && redirect) begin
                        pcsel = 1; nxt[0] = 0;
                        m_flush = (m_flush + 1) % MOD;
                    end else if (m_pipe[0] && halt_req) begin
                        nxt[0] = 0;
                        m_mode = M_DRAIN;
                    end
                end
                if (ret) m_ret = (m_ret + 1) % MOD;
            end
        end
        e.ctl = {pcwe, pcsel, ifid, down, down, down,
                 m_pipe[0], m_pipe[1], m_pipe[2], m_pipe[3], ret, hlt};
        m_pipe = nxt;
    endtask

    task automatic step();
        exp_t e;
        predict(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // Asserts reset mid-cycle and checks the outputs before any clock edge.
    task automatic apply_reset();
        exp_t e;
        rst_n = 1'b0;
        hazard_stall = 0; redirect = 0; dmem_req = 0; dmem_ready = 0; halt_req = 0;
        #1;
        model_reset();
        e = '0;
        e.tag = cyc_no;
        sb_q.push_back(e);
        ->chk_ev;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs(input int halt_pct);
        hazard_stall = ($urandom_range(99, 0) < 20);
        redirect     = ($urandom_range(99, 0) < 20);
        dmem_req     = ($urandom_range(99, 0) < 50);
        dmem_ready   = ($urandom_range(99, 0) < 65);
        halt_req     = ($urandom_range(99, 0) < halt_pct);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ctl", int'(e.tag),
                      {20'd0, pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                       v_id, v_ex, v_mem, v_wb, retire, halted},
                      {20'd0, e.ctl});
                check("cycle_cnt",  int'(e.tag), 32'(cycle_cnt),  32'(e.cyc));
                check("retire_cnt", int'(e.tag), 32'(retire_cnt), 32'(e.ret));
                check("stall_cnt",  int'(e.tag), 32'(stall_cnt),  32'(e.stl));
                check("flush_cnt",  int'(e.tag), 32'(flush_cnt),  32'(e.fl));
            end
        end
    end

    initial begin : stimulus
        int n;
        #1;
        apply_reset();
        repeat (10) step();

        hazard_stall = 1; step(); hazard_stall = 0;
        repeat (4) step();

        redirect = 1; hazard_stall = 1; step();
        hazard_stall = 0; step();
        redirect = 0;
        repeat (3) step();

        dmem_req = 1; dmem_ready = 0;
        repeat (3) step();
        dmem_ready = 1; step();
        dmem_req = 0; dmem_ready = 0;
        repeat (3) step();

        halt_req = 1; step(); halt_req = 0;
        dmem_req = 1; dmem_ready = 0;
        repeat (2) step();
        dmem_ready = 1; step();
        dmem_req = 0; dmem_ready = 0;
        repeat (8) step();

        apply_reset();
        repeat (6) step();
        dmem_req = 1; dmem_ready = 0;
        repeat (3) step();
        apply_reset();
        repeat (4) step();

        apply_reset();
        repeat (600) begin rand_inputs(0); step(); end

        for (int s = 0; s < 14; s++) begin
            apply_reset();
            n = $urandom_range(220, 60);
            repeat (n) begin
                rand_inputs((s % 3 == 0) ? 0 : 4);
                step();
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_empty", cyc_no, 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
